// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 3;

  // Depth need not be a power of two, so range-check every address explicitly.
  function automatic logic addr_valid(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_issue_addr,
  input  logic [ADDR_W-1:0] i_q_addr_a,
  input  logic [ADDR_W-1:0] i_q_addr_b,
  output logic              o_pend_a,
  output logic              o_pend_b
);

  logic [DEPTH-1:0] r_pending;
  logic             w_clr_en;
  logic             w_set_en;

  assign w_clr_en = i_write && addr_valid(32'(i_wr_addr), DEPTH)
                    && !((ZERO_REG != 0) && (i_wr_addr == '0));
  assign w_set_en = i_issue && addr_valid(32'(i_issue_addr), DEPTH)
                    && !((ZERO_REG != 0) && (i_issue_addr == '0));

  // NOTE: non-blocking assignments; the set follows the clear so a same-edge
  // issue (the newer producer) overrides the writeback's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_clr_en && (i_wr_addr == ADDR_W'(i)))    r_pending[i] <= 1'b0;
        if (w_set_en && (i_issue_addr == ADDR_W'(i))) r_pending[i] <= 1'b1;
      end
    end
  end

  // NOTE: defaults first so an out-of-range query address cannot infer a latch.
  always_comb begin
    o_pend_a = 1'b0;
    o_pend_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_q_addr_a == ADDR_W'(i)) o_pend_a = r_pending[i];
      if (i_q_addr_b == ADDR_W'(i)) o_pend_b = r_pending[i];
    end
  end

endmodule

// File: rtl/regfile_nxw.sv
// DEPTH x WIDTH register file: two combinational read ports, one write port,
// optional write-through bypass and hardwired-zero r0, with a pending-write scoreboard.
module regfile_nxw
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issueAddr,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [WIDTH-1:0]  rdDataA,
  output logic              readyA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [WIDTH-1:0]  rdDataB,
  output logic              readyB
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_wr_valid;
  logic              w_wr_en;
  logic              w_pend [2];
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [WIDTH-1:0]  w_rd_data [2];
  logic              w_rd_ready [2];

  assign w_wr_valid = write && addr_valid(32'(wrAddr), DEPTH);
  assign w_wr_en    = w_wr_valid && !((ZERO_REG != 0) && (wrAddr == '0));

  // NOTE: the array is reset because decode relies on all registers reading 0
  // after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_en && (wrAddr == ADDR_W'(i))) r_mem[i] <= wrData;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_write      (write),
    .i_wr_addr    (wrAddr),
    .i_issue      (issue),
    .i_issue_addr (issueAddr),
    .i_q_addr_a   (rdAddrA),
    .i_q_addr_b   (rdAddrB),
    .o_pend_a     (w_pend[0]),
    .o_pend_b     (w_pend[1])
  );

  assign w_rd_addr[0] = rdAddrA;
  assign w_rd_addr[1] = rdAddrB;

  // Priority: hardwired zero, then forwarded write data, then stored value.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_data[p]  = '0;
      w_rd_ready[p] = 1'b1;
      if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) begin
        w_rd_data[p] = '0;
      end else if ((BYPASS != 0) && w_wr_valid && (wrAddr == w_rd_addr[p])) begin
        w_rd_data[p] = wrData;
      end else if (addr_valid(32'(w_rd_addr[p]), DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_rd_addr[p] == ADDR_W'(i)) w_rd_data[p] = r_mem[i];
        end
        w_rd_ready[p] = !w_pend[p];
      end
    end
  end

  assign rdDataA = w_rd_data[0];
  assign readyA  = w_rd_ready[0];
  assign rdDataB = w_rd_data[1];
  assign readyB  = w_rd_ready[1];

endmodule

// File: doc/regfile_nxw.md
# regfile_nxw

Parametrised multi-port register file, successor to the fixed 4x16 two-read/one-write register file in the datapath. DEPTH x WIDTH storage, two combinational read ports, one synchronous write port, optional write-through bypass, optional hardwired-zero register 0, and a per-register pending-write scoreboard. The decode stage uses the scoreboard to stall on outstanding writebacks.

## Interface
- WIDTH, 16, data width in bits.
- DEPTH, 4, number of registers (2..2**ADDR_W; need not be a power of 2).
- ADDR_W, 3, address width of every address port.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports.
- ZERO_REG, 0, 1 = register 0 reads as 0; writes and issues to it are ignored.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- write  in  1  write enable (writeback).
- wrAddr  in  ADDR_W  write address.
- wrData  in  WIDTH  write data.
- issue  in  1  marks issue_addr as having a write in flight.
- issueAddr  in  ADDR_W  destination of the issued instruction.
- rdAddrA  in  ADDR_W  read address, port A.
- rdDataA  out  WIDTH  read data, port A.
- readyA  out  1  port A data is current (no outstanding write).
- rdAddrB  in  ADDR_W  read address, port B.
- rdDataB  out  WIDTH  read data, port B.
- readyB  out  1  port B data is current.

## Operation
- Storage: reg[0..DEPTH-1], WIDTH bits each; pending[0..DEPTH-1], 1 bit each.
- Address valid iff addr < DEPTH. Invalid read: data 0, ready 1. Invalid write/issue: no effect.
- Read (per port, combinational), in priority order:
  - ZERO_REG && addr==0: data 0, ready 1.
  - BYPASS && write && wrAddr==addr && valid: data wrData, ready 1.
  - Otherwise: data reg[addr], ready = !pending[addr].
- Write: on edge with write=1 and valid wrAddr (and not ZERO_REG reg 0), reg[wrAddr] <= wrData and pending[wrAddr] <= 0.
- Issue: on edge with issue=1 and valid issueAddr (and not ZERO_REG reg 0), pending[issueAddr] <= 1.
- Issue and write to the same address in one cycle: reg updated, pending ends at 1. The issue is a newer producer and wins.
- Issue and write to different addresses: both take effect independently.
- Write to a register with pending=0 is legal: data updated, pending stays 0.
- No internal counting. At most one outstanding write per register. Re-issue while pending is legal and leaves pending at 1.

## Timing
- Reset (rst_n low, asynchronous): all reg = 0, all pending = 0. Consequently rdDataA/B = 0 and readyA/B = 1 while in reset.
- Reset release is synchronised by the system. The first state update happens on the first rising edge with rst_n high.
- Read latency 0 cycles (combinational from address, storage, and the bypass inputs).
- Write visible:
  - BYPASS=1: same cycle.
  - BYPASS=0: cycle after the edge.
- Issue visible on ready: cycle after the edge.
- rst_n asserted mid-operation clears all storage and pending bits immediately. No write on the same edge survives.
- No combinational path from issue to any output.

## Structure
- Shared package regfile_pkg:
  - default WIDTH/DEPTH/ADDR_W localparams;
  - function addr_valid(addr, DEPTH).
- Sub-module regfile_scoreboard: pending vector plus set/clear logic. It takes the same clk/rst_n, issue/write ports and two query addresses, and returns two pending bits.
- Top: storage array, read muxes with bypass/zero/invalid handling, scoreboard instance.

## Test plan
- Reset then read all addresses (DEPTH=4, ADDR_W=3): rdDataA/B = 0, readyA/B = 1 for addr 0..7.
- Write 0xBEEF to r2, 0x1234 to r3; next cycle rdAddrA=2, rdAddrB=3 -> 0xBEEF, 0x1234. Write to addr 5 -> read addr 5 still 0, no register changed.
- BYPASS=1: write 0xA5A5 to r1 with rdAddrA=1 in the same cycle -> rdDataA=0xA5A5, readyA=1 that cycle. BYPASS=0 -> old value that cycle, 0xA5A5 next.
- Issue r1 -> next cycle readyA=0 at rdAddrA=1. Write r1 0x0042 -> next cycle readyA=1, data 0x0042. Issue and write r1 together -> readyA=0 afterwards, data updated.
- ZERO_REG=1: write 0xFFFF and issue to r0 -> r0 reads 0, ready 1 on every cycle.
- Assert rst_n low between edges after writes and issues -> outputs immediately 0/ready 1. The next write after release works normally.
